// File: rtl/ans_encoder_if.sv
// Stream and table-lookup signals of the rANS encoder: symbol input, frequency table read,
// and the encoded-nibble output.
interface ans_encoder_if;
  logic [3:0]  in_sym;
  logic        in_vld;
  logic        in_rdy;
  logic        in_last;
  logic        read_type;
  logic [3:0]  read_query;
  logic [15:0] read_result;
  logic        read_rdy;
  logic [3:0]  out_nib;
  logic        out_vld;
  logic        out_rdy;
  logic        out_last;

  modport master (
    input  in_sym, in_vld, in_last, read_result, read_rdy, out_rdy,
    output in_rdy, read_type, read_query, out_nib, out_vld, out_last
  );

  modport slave (
    output in_sym, in_vld, in_last, read_result, read_rdy, out_rdy,
    input  in_rdy, read_type, read_query, out_nib, out_vld, out_last
  );
endinterface

// File: rtl/ans_encoder.sv
// rANS encoder: 16-bit state, M=256, nibble renormalisation, sequential restoring divide,
// and a 4-nibble state flush after the last symbol.
module ans_encoder #(
  parameter int SYM_WIDTH   = 4,
  parameter int PROB_BITS   = 8,
  parameter int STATE_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena_i,
  ans_encoder_if.master bus,
  output logic          err_o
);
  localparam logic [STATE_WIDTH-1:0] X_LOW = STATE_WIDTH'(4096);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_RENORM, S_DIV, S_UPDATE, S_FLUSH, S_ERR
  } state_t;

  state_t                 state_q, state_d;
  logic [STATE_WIDTH-1:0] x_q, x_d;
  logic [STATE_WIDTH-1:0] dq_q, dq_d;
  logic [SYM_WIDTH-1:0]   sym_q, sym_d;
  logic                   last_q, last_d;
  logic [PROB_BITS-1:0]   f_q, f_d, c_q, c_d, rem_q, rem_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [1:0]             fcnt_q, fcnt_d;

  logic [PROB_BITS-1:0]   rd_freq, rd_cum, rem_sub;
  logic [PROB_BITS:0]     rd_sum, rem_shift;
  logic                   renorm_need, rem_ge;
  logic [STATE_WIDTH-1:0] x_upd;

  assign rd_freq     = bus.read_result[15:8];
  assign rd_cum      = bus.read_result[7:0];
  assign rd_sum      = {1'b0, rd_freq} + {1'b0, rd_cum};
  assign renorm_need = {1'b0, x_q} >= {1'b0, f_q, 8'h00};
  // Remainder stays below f, so the difference fits in PROB_BITS even when the shift overflows.
  assign rem_shift   = {rem_q, dq_q[STATE_WIDTH-1]};
  assign rem_ge      = rem_shift >= {1'b0, f_q};
  assign rem_sub     = rem_shift[PROB_BITS-1:0] - f_q;
  assign x_upd       = {dq_q[7:0], 8'h00} + {8'h00, rem_q} + {8'h00, c_q};

  assign bus.read_type  = 1'b0;
  assign bus.read_query = sym_q;
  assign err_o          = (state_q == S_ERR);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    dq_d         = dq_q;
    sym_d        = sym_q;
    last_d       = last_q;
    f_d          = f_q;
    c_d          = c_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    fcnt_d       = fcnt_q;
    bus.in_rdy   = 1'b0;
    bus.out_vld  = 1'b0;
    bus.out_nib  = x_q[3:0];
    bus.out_last = 1'b0;
    if (ena_i) begin
      case (state_q)
        S_IDLE: begin
          bus.in_rdy = 1'b1;
          if (bus.in_vld) begin
            sym_d   = bus.in_sym;
            last_d  = bus.in_last;
            state_d = S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (bus.read_rdy) begin
            f_d = rd_freq;
            c_d = rd_cum;
            if (rd_freq == '0 || rd_sum > 9'd256) state_d = S_ERR;
            else                                  state_d = S_RENORM;
          end
        end
        S_RENORM: begin
          if (renorm_need) begin
            bus.out_vld = 1'b1;
            if (bus.out_rdy) x_d = x_q >> 4;
          end else begin
            dq_d    = x_q;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = S_DIV;
          end
        end
        S_DIV: begin
          if (rem_ge) begin
            rem_d = rem_sub;
            dq_d  = {dq_q[STATE_WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_shift[PROB_BITS-1:0];
            dq_d  = {dq_q[STATE_WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = S_UPDATE;
        end
        S_UPDATE: begin
          x_d     = x_upd;
          state_d = last_q ? S_FLUSH : S_IDLE;
        end
        S_FLUSH: begin
          bus.out_vld  = 1'b1;
          bus.out_last = (fcnt_q == 2'd3);
          case (fcnt_q)
            2'd0:    bus.out_nib = x_q[3:0];
            2'd1:    bus.out_nib = x_q[7:4];
            2'd2:    bus.out_nib = x_q[11:8];
            default: bus.out_nib = x_q[15:12];
          endcase
          if (bus.out_rdy) begin
            if (fcnt_q == 2'd3) begin
              fcnt_d  = '0;
              x_d     = X_LOW;
              state_d = S_IDLE;
            end else begin
              fcnt_d = fcnt_q + 2'd1;
            end
          end
        end
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= X_LOW;
      dq_q    <= '0;
      sym_q   <= '0;
      last_q  <= 1'b0;
      f_q     <= '0;
      c_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      dq_q    <= dq_d;
      sym_q   <= sym_d;
      last_q  <= last_d;
      f_q     <= f_d;
      c_q     <= c_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
    end
  end
endmodule

// File: tb/tb_ans_encoder.sv
// Scoreboard bench for ans_encoder: directed symbols push hand-computed nibbles,
// a negedge monitor pops and compares every output transfer.
module tb_ans_encoder;
  logic clk = 1'b0;
  logic rst;
  logic ena;
  logic err;

  ans_encoder_if bus ();

  ans_encoder dut (
    .clk   (clk),
    .rst   (rst),
    .ena_i (ena),
    .bus   (bus.master),
    .err_o (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] tbl [16];
  logic [4:0]  exp_q [$];
  logic [4:0]  mon_exp;

  assign bus.read_result = tbl[bus.read_query];

  function automatic void check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endfunction

  // Monitor: a transfer happens at the next rising edge whenever vld and rdy are both high here.
  always @(negedge clk) begin
    if (!rst && bus.out_vld && bus.out_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_nibble: got nibble %h last %0d, required no output", bus.out_nib, bus.out_last);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("out nibble %h last %0d (expected %h last %0d)", bus.out_nib, bus.out_last, mon_exp[3:0], mon_exp[4]);
        check("nibble", {27'd0, bus.out_last, bus.out_nib}, {27'd0, mon_exp});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic l, input logic [3:0] n);
    exp_q.push_back({l, n});
  endtask

  task automatic send(input logic [3:0] s, input logic l, input int delay);
    int g = 0;
    while (!bus.in_rdy && g < 300) begin
      tick();
      g++;
    end
    check("in_rdy_before_send", bus.in_rdy, 1);
    bus.in_sym   = s;
    bus.in_last  = l;
    bus.in_vld   = 1'b1;
    bus.read_rdy = (delay == 0);
    tick();
    bus.in_vld = 1'b0;
    $display("sent sym %0d last %0d read delay %0d", s, l, delay);
    check("read_query", bus.read_query, s);
    repeat (delay) tick();
    bus.read_rdy = 1'b1;
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (!bus.in_rdy && n < 1000) begin
      tick();
      n++;
    end
    check("in_rdy_timeout", int'(n < 1000), 1);
  endtask

  task automatic wait_out_vld();
    int g = 0;
    while (!bus.out_vld && g < 200) begin
      tick();
      g++;
    end
    check("out_vld_timeout", bus.out_vld, 1);
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || !bus.in_rdy) && g < 1000) begin
      tick();
      g++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_idle", bus.in_rdy, 1);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    check("rst_out_vld", bus.out_vld, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_err", err, 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_in_rdy", bus.in_rdy, 1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) tbl[i] = {8'd16, 8'(i * 16)};
    tbl[0] = {8'd128, 8'd0};
    tbl[1] = {8'd1,   8'd255};
    tbl[2] = {8'd0,   8'd0};
    tbl[3] = {8'd200, 8'd100};
    tbl[4] = {8'd64,  8'd128};

    rst = 1'b1;
    ena = 1'b1;
    bus.in_sym   = '0;
    bus.in_vld   = 1'b0;
    bus.in_last  = 1'b0;
    bus.read_rdy = 1'b1;
    bus.out_rdy  = 1'b1;
    repeat (3) tick();
    check("reset_out_vld", bus.out_vld, 0);
    check("reset_err", err, 0);
    rst = 1'b0;
    tick();
    check("reset_in_rdy", bus.in_rdy, 1);
    check("reset_out_vld_after", bus.out_vld, 0);
    check("reset_read_type", bus.read_type, 0);

    ena = 1'b0;
    #1;
    check("ena_low_in_rdy", bus.in_rdy, 0);
    ena = 1'b1;
    tick();

    // f=128 c=0 from x=4096: x=8192
    push(0, 4'h0); push(0, 4'h0); push(0, 4'h0); push(1, 4'h2);
    send(4'd0, 1'b1, 0);
    drain();

    // f=1 c=255: renorm 0,0 then x=0x10FF
    push(0, 4'h0); push(0, 4'h0);
    push(0, 4'hF); push(0, 4'hF); push(0, 4'h0); push(1, 4'h1);
    send(4'd1, 1'b1, 0);
    drain();

    // f=64 c=128 -> x=16512; then f=128 c=0 -> q=129 -> x=0x8100
    push(0, 4'h0); push(0, 4'h0); push(0, 4'h1); push(1, 4'h8);
    send(4'd4, 1'b0, 0);
    wait_rdy(n);
    check("latency_cycles", n, 19);
    send(4'd0, 1'b1, 0);
    drain();

    // x=0x4080, f=1 c=255: renorm 0,8 -> x=0x40 -> x=0x40FF; stall on the nibble 8
    bus.out_rdy = 1'b0;
    push(0, 4'h0); push(0, 4'h8);
    push(0, 4'hF); push(0, 4'hF); push(0, 4'h0); push(1, 4'h4);
    send(4'd4, 1'b0, 0);
    wait_rdy(n);
    send(4'd1, 1'b1, 0);
    wait_out_vld();
    bus.out_rdy = 1'b1;
    tick();
    bus.out_rdy = 1'b0;
    repeat (5) begin
      check("stall_out_vld", bus.out_vld, 1);
      check("stall_out_nib", bus.out_nib, 8);
      tick();
    end
    bus.out_rdy = 1'b1;
    drain();

    // delayed table answer gives the same stream
    push(0, 4'h0); push(0, 4'h0); push(0, 4'h0); push(1, 4'h2);
    send(4'd0, 1'b1, 3);
    drain();

    // zero frequency
    send(4'd2, 1'b0, 0);
    repeat (3) tick();
    check("err_f0", err, 1);
    check("err_f0_in_rdy", bus.in_rdy, 0);
    check("err_f0_out_vld", bus.out_vld, 0);
    repeat (5) tick();
    check("err_f0_sticky", err, 1);
    reset_pulse();

    // f+c = 300 > 256
    send(4'd3, 1'b0, 0);
    repeat (3) tick();
    check("err_sum", err, 1);
    check("err_sum_in_rdy", bus.in_rdy, 0);
    reset_pulse();

    // reset during DIV cycle 8 after x was moved off 4096
    send(4'd4, 1'b0, 0);
    wait_rdy(n);
    send(4'd0, 1'b1, 0);
    repeat (9) tick();
    reset_pulse();
    push(0, 4'h0); push(0, 4'h0); push(0, 4'h0); push(1, 4'h2);
    send(4'd0, 1'b1, 0);
    drain();

    // reset while flush nibble 2 is presented
    bus.out_rdy = 1'b0;
    push(0, 4'h0); push(0, 4'h0); push(0, 4'hF);
    send(4'd1, 1'b1, 0);
    repeat (3) begin
      wait_out_vld();
      bus.out_rdy = 1'b1;
      tick();
      bus.out_rdy = 1'b0;
    end
    wait_out_vld();
    check("flush2_nib", bus.out_nib, 15);
    check("flush2_last", bus.out_last, 0);
    check("flush_in_rdy", bus.in_rdy, 0);
    reset_pulse();
    check("flush_rst_queue", exp_q.size(), 0);
    bus.out_rdy = 1'b1;
    push(0, 4'h0); push(0, 4'h0); push(0, 4'h0); push(1, 4'h2);
    send(4'd0, 1'b1, 0);
    drain();

    repeat (5) tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ans_encoder.md
ANS_ENCODER -- requirements
Module: ans_encoder

Interface
REQ-001 Parameter SYM_WIDTH, default 4, symbol width (16-symbol alphabet); only the default is supported.
REQ-002 Parameter PROB_BITS, default 8, log2 of total frequency M=256; only the default is supported.
REQ-003 Parameter STATE_WIDTH, default 16, rANS state width; lower bound L=4096, valid state range [4096, 65535].
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 ena  in  1  enable; when low, all state held, in_rdy=0, out_vld=0.
REQ-007 in  in  4  symbol to encode.
REQ-008 in_vld / in_rdy  in / out  1 / 1  symbol handshake; transfer when both are high on a clock edge.
REQ-009 in_last  in  1  sampled with the symbol; marks the final symbol of the stream.
REQ-010 read_type  out  1  table read type; constant 0 (by-symbol lookup).
REQ-011 read_query  out  4  symbol being looked up.
REQ-012 read_result  in  16  {freq[15:8], cum[7:0]} for read_query; valid in any cycle where read_rdy=1.
REQ-013 read_rdy  in  1  table result valid.
REQ-014 out  out  4  encoded nibble.
REQ-015 out_vld / out_rdy  out / in  1 / 1  nibble handshake; transfer when both are high on a clock edge.
REQ-016 out_last  out  1  high with the final flush nibble.
REQ-017 err  out  1  sticky error flag.

Function
REQ-018 FSM states: IDLE, LOOKUP, RENORM, DIV, UPDATE, FLUSH, ERR.
REQ-019 IDLE: in_rdy=ena; on transfer, capture sym and last; next state LOOKUP.
REQ-020 LOOKUP: read_query=captured sym; on read_rdy, capture f=freq and c=cum; go to ERR if f=0 or f+c>256 (9-bit sum), else go to RENORM.
REQ-021 LOOKUP with read_rdy=0: wait indefinitely, no timeout.
REQ-022 RENORM: if x >= f<<8 (17-bit compare), assert out_vld with out=x[3:0]; on transfer, x <= x>>4 and remain in RENORM; else go to DIV.
REQ-023 RENORM: out and x stay stable while out_vld=1 and out_rdy=0.
REQ-024 DIV: restoring divide of x by f, 1 quotient bit per cycle, exactly 16 cycles; yields q<256 and r<f.
REQ-025 UPDATE: x <= (q<<8)+r+c in 1 cycle; result is always in [4096, 65535], no overflow.
REQ-026 UPDATE: go to FLUSH if last, else go to IDLE.
REQ-027 FLUSH: emit x as 4 nibbles, LSB nibble first (x[3:0], x[7:4], x[11:8], x[15:12]); out_last=1 only with the 4th.
REQ-028 FLUSH: after the 4th transfer, x <= 4096 and return to IDLE.
REQ-029 ERR: err=1, in_rdy=0, out_vld=0; state left only by rst.
REQ-030 Latency, symbol accept to next in_rdy (no renorm, table and sink always ready): 1 LOOKUP + 1 RENORM + 16 DIV + 1 UPDATE = 19 cycles.
REQ-031 in_rdy=0 in every state except IDLE; no symbol is accepted during FLUSH.
REQ-032 out_vld is asserted only in RENORM and FLUSH.

Reset
REQ-033 rst asserted: immediately state=IDLE, x=4096, out_vld=0, out_last=0, err=0, DIV counter and flush counter=0.
REQ-034 rst mid-operation (any state): in-flight symbol discarded, no partial nibble emitted.
REQ-035 First rising edge after rst deasserts: in_rdy=1 if ena=1.

Verification
REQ-036 Reset check: after rst -> in_rdy=1, out_vld=0, err=0; flush of an empty stream is not possible (no symbol is accepted without a transfer).
REQ-037 sym with f=128, c=0, last=1, x=4096 -> no renorm nibbles, x=8192, then flush nibbles 0,0,0,2 with out_last on the 2.
REQ-038 sym with f=1, c=255, last=1 -> renorm nibbles 0,0 (x=4096->256->16), x=4351 (0x10FF), then flush nibbles F,F,0,1.
REQ-039 read_result freq=0 (or f=200, c=100) -> err=1, in_rdy=0 thereafter; after rst -> err=0.
REQ-040 out_rdy held low 5 cycles during a RENORM nibble -> out and x unchanged, exactly one nibble transferred when out_rdy rises; read_rdy delayed 3 cycles -> identical output stream.
REQ-041 rst asserted on DIV cycle 8, and separately during FLUSH nibble 2 -> outputs at reset values at once, x=4096, next stream encodes correctly.
